// File: rtl/apb_global_pkg.sv
// Shared types and defaults for the APB completer register bank.
package apb_global_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, WAIT, ACCESS_DONE} fsm_state_e;

  localparam int DEF_ADDR_WIDTH  = 32;
  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_NUM_REGS    = 16;
  localparam int DEF_WAIT_STATES = 0;

  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/apb_slave_regfile.sv
// Register storage with a byte-strobed write port and a combinational read mux.
module apb_slave_regfile
  import apb_global_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REGS   = DEF_NUM_REGS,
  localparam int STRB_W    = strb_width(DATA_WIDTH),
  localparam int IDX_W     = $clog2(NUM_REGS)
) (
  input  logic                  pclk,
  input  logic                  preset_n,
  input  logic                  we,
  input  logic [IDX_W-1:0]      widx,
  input  logic [STRB_W-1:0]     wstrb,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]      ridx,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] mem_d [NUM_REGS];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem_d[widx][b*8 +: 8] = wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[ridx];

endmodule

// File: rtl/apb_slave_regbank.sv
// APB4 completer backed by a strobed register bank, with programmable wait states.
// Optional write protection of the upper bank half: define APB_SLAVE_PROT_CHECK_EN.
//
// state       | meaning
// IDLE        | no transfer; watching for a setup phase
// SETUP       | first access cycle of a transfer that has wait states
// WAIT        | further access cycles counting down to completion
// ACCESS_DONE | pready cycle; response and write take effect here
module apb_slave_regbank
  import apb_global_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int NUM_REGS    = DEF_NUM_REGS,
  parameter int WAIT_STATES = DEF_WAIT_STATES
) (
  input  logic                    pclk,
  input  logic                    preset_n,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic [2:0]              pprot,
  output logic                    pready,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pslverr
);

  localparam int STRB_W = strb_width(DATA_WIDTH);
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] BANK_BYTES = ADDR_WIDTH'(NUM_REGS * STRB_W);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK   = ADDR_WIDTH'(STRB_W - 1);
  localparam logic [3:0]            WS         = 4'(WAIT_STATES);

  fsm_state_e            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     strb_q, strb_d;
  logic [2:0]            prot_q, prot_d;
  logic                  pready_q, pready_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  pslverr_q, pslverr_d;

  logic                  take_new, finish, we, err, err_prot;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic                  cur_write;
  logic [DATA_WIDTH-1:0] cur_wdata, rd_data;
  logic [STRB_W-1:0]     cur_strb;
  logic [2:0]            cur_prot;
  logic [IDX_W-1:0]      idx;

  // A zero-wait transfer completes off the live setup-phase bus, so decode
  // works on whichever request is current rather than only the latched copy.
  assign take_new  = psel & ~penable & ((state_q == IDLE) | (state_q == ACCESS_DONE));
  assign cur_addr  = take_new ? paddr  : addr_q;
  assign cur_write = take_new ? pwrite : write_q;
  assign cur_wdata = take_new ? pwdata : wdata_q;
  assign cur_strb  = take_new ? pstrb  : strb_q;
  assign cur_prot  = take_new ? pprot  : prot_q;
  assign idx       = cur_addr[OFF_W +: IDX_W];

`ifdef APB_SLAVE_PROT_CHECK_EN
  logic unused_prot;
  assign err_prot    = cur_write & ~cur_prot[0] & idx[IDX_W-1];
  assign unused_prot = ^cur_prot[2:1];
`else
  logic unused_prot;
  assign err_prot    = 1'b0;
  assign unused_prot = ^cur_prot;
`endif

  assign err = (cur_addr >= BANK_BYTES) | ((cur_addr & OFF_MASK) != '0) | err_prot;
  assign we  = finish & cur_write & ~err;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    prot_d    = prot_q;
    pready_d  = 1'b0;
    prdata_d  = '0;
    pslverr_d = 1'b0;
    finish    = 1'b0;
    case (state_q)
      IDLE, ACCESS_DONE: begin
        state_d = IDLE;
        if (take_new) begin
          addr_d  = paddr;
          write_d = pwrite;
          wdata_d = pwdata;
          strb_d  = pstrb;
          prot_d  = pprot;
          cnt_d   = WS;
          if (WS == 4'd0) finish = 1'b1;
          else            state_d = SETUP;
        end
      end
      SETUP, WAIT: begin
        if (!psel) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q <= 4'd1) begin
          finish = 1'b1;
          cnt_d  = 4'd0;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          state_d = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
    if (finish) begin
      state_d   = ACCESS_DONE;
      pready_d  = 1'b1;
      pslverr_d = err;
      prdata_d  = (!cur_write && !err) ? rd_data : '0;
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      prot_q    <= '0;
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      prot_q    <= prot_d;
      pready_q  <= pready_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
    end
  end

  apb_slave_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_regfile (
    .pclk     (pclk),
    .preset_n (preset_n),
    .we       (we),
    .widx     (idx),
    .wstrb    (cur_strb),
    .wdata    (cur_wdata),
    .ridx     (idx),
    .rdata    (rd_data)
  );

  assign pready  = pready_q;
  assign prdata  = prdata_q;
  assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Directed bench: one zero-wait and one three-wait completer on a shared APB bus.
module tb_apb_slave_regbank;

  logic        pclk = 1'b0;
  logic        preset_n;
  logic        psel0, psel3, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic        pready0, pslverr0, pready3, pslverr3;
  logic [31:0] prdata0, prdata3;

  int n_chk = 0;
  int n_bad = 0;

  always #5 pclk = ~pclk;

  apb_slave_regbank #(.WAIT_STATES(0)) u_dut0 (
    .pclk(pclk), .preset_n(preset_n), .psel(psel0), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pprot(pprot), .pready(pready0), .prdata(prdata0), .pslverr(pslverr0)
  );

  apb_slave_regbank #(.WAIT_STATES(3)) u_dut3 (
    .pclk(pclk), .preset_n(preset_n), .psel(psel3), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pprot(pprot), .pready(pready3), .prdata(prdata3), .pslverr(pslverr3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    @(posedge pclk); #1;
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
  endtask

  // Full transfer; leaves the bus in its access phase so a following call is back-to-back.
  task automatic xfer(input string tag, input int d, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] st, input logic [2:0] pr,
                      output logic [31:0] rd, output logic er, output int cyc);
    logic done;
    @(posedge pclk); #1;
    psel0 = (d == 0); psel3 = (d != 0); penable = 1'b0;
    pwrite = wr; paddr = a; pwdata = wd; pstrb = st; pprot = pr;
    @(posedge pclk); #1;
    penable = 1'b1;
    cyc = 2; done = 1'b0; rd = '0; er = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge pclk);
      if ((d == 0) ? pready0 : pready3) begin
        rd = (d == 0) ? prdata0 : prdata3;
        er = (d == 0) ? pslverr0 : pslverr3;
        done = 1'b1;
      end else begin
        @(posedge pclk); #1;
        cyc++;
      end
    end
    if (!done) chk({tag, "_timeout"}, 32'((d == 0) ? pready0 : pready3), 32'd1);
  endtask

  logic [31:0] rd;
  logic        er;
  int          cyc, hits;

  initial begin
    preset_n = 1'b0; psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
    repeat (2) @(posedge pclk);
    #1;
    chk("rst_rdy0", 32'(pready0), 32'd0);
    chk("rst_rd0", prdata0, 32'd0);
    chk("rst_err0", 32'(pslverr0), 32'd0);
    chk("rst_rdy3", 32'(pready3), 32'd0);
    preset_n = 1'b1;
    bus_idle();

    // zero-wait write then read
    xfer("w04", 0, 1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 3'b001, rd, er, cyc);
    chk("w04_err", 32'(er), 32'd0);
    chk("w04_cyc", 32'(cyc), 32'd2);
    bus_idle();
    xfer("r04", 0, 1'b0, 32'h04, 32'h0, 4'h0, 3'b001, rd, er, cyc);
    chk("r04_data", rd, 32'hDEADBEEF);
    chk("r04_err", 32'(er), 32'd0);
    chk("r04_cyc", 32'(cyc), 32'd2);
    bus_idle();

    // three wait states
    xfer("r00w3", 3, 1'b0, 32'h00, 32'h0, 4'h0, 3'b001, rd, er, cyc);
    chk("r00w3_data", rd, 32'h0);
    chk("r00w3_err", 32'(er), 32'd0);
    chk("r00w3_cyc", 32'(cyc), 32'd5);
    bus_idle();

    // partial strobes
    xfer("w08a", 0, 1'b1, 32'h08, 32'hFFFFFFFF, 4'hF, 3'b001, rd, er, cyc);
    bus_idle();
    xfer("w08b", 0, 1'b1, 32'h08, 32'h11223344, 4'b0101, 3'b001, rd, er, cyc);
    bus_idle();
    xfer("r08", 0, 1'b0, 32'h08, 32'h0, 4'h0, 3'b001, rd, er, cyc);
    chk("strb_data", rd, 32'hFF22FF44);
    bus_idle();

    // pstrb=0 is a no-op with OKAY
    xfer("w04z", 0, 1'b1, 32'h04, 32'h00000000, 4'h0, 3'b001, rd, er, cyc);
    chk("nostrb_err", 32'(er), 32'd0);
    bus_idle();

    // address errors
    xfer("r40", 0, 1'b0, 32'h40, 32'h0, 4'h0, 3'b001, rd, er, cyc);
    chk("oor_err", 32'(er), 32'd1);
    chk("oor_data", rd, 32'h0);
    bus_idle();
    xfer("w02", 0, 1'b1, 32'h02, 32'h12345678, 4'hF, 3'b001, rd, er, cyc);
    chk("mis_err", 32'(er), 32'd1);
    bus_idle();
    xfer("r00", 0, 1'b0, 32'h00, 32'h0, 4'h0, 3'b001, rd, er, cyc);
    chk("mis_nowrite", rd, 32'h0);
    bus_idle();
    xfer("r04b", 0, 1'b0, 32'h04, 32'h0, 4'h0, 3'b001, rd, er, cyc);
    chk("r04_kept", rd, 32'hDEADBEEF);
    bus_idle();

    // back-to-back write then read
    xfer("w0c", 0, 1'b1, 32'h0C, 32'hCAFEF00D, 4'hF, 3'b001, rd, er, cyc);
    chk("b2b_werr", 32'(er), 32'd0);
    xfer("r0c", 0, 1'b0, 32'h0C, 32'h0, 4'h0, 3'b001, rd, er, cyc);
    chk("b2b_data", rd, 32'hCAFEF00D);
    chk("b2b_cyc", 32'(cyc), 32'd2);
    bus_idle();

    // penable without setup phase is ignored
    @(posedge pclk); #1;
    psel0 = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h04; pwdata = 32'h0; pstrb = 4'hF;
    hits = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge pclk);
      if (pready0) hits++;
    end
    chk("noset_rdy", 32'(hits), 32'd0);
    bus_idle();
    xfer("r04c", 0, 1'b0, 32'h04, 32'h0, 4'h0, 3'b001, rd, er, cyc);
    chk("noset_data", rd, 32'hDEADBEEF);
    bus_idle();

    // psel dropped mid-wait aborts
    @(posedge pclk); #1;
    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'hA5A5A5A5;
    pstrb = 4'hF; pprot = 3'b001;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel3 = 1'b0; penable = 1'b0;
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge pclk);
      if (pready3) hits++;
    end
    chk("abort_rdy", 32'(hits), 32'd0);
    xfer("r10", 3, 1'b0, 32'h10, 32'h0, 4'h0, 3'b001, rd, er, cyc);
    chk("abort_data", rd, 32'h0);
    bus_idle();

    // upper-half protection
    xfer("w20p0", 0, 1'b1, 32'h20, 32'h13579BDF, 4'hF, 3'b000, rd, er, cyc);
`ifdef APB_SLAVE_PROT_CHECK_EN
    chk("prot0_err", 32'(er), 32'd1);
`else
    chk("prot0_err", 32'(er), 32'd0);
`endif
    bus_idle();
    xfer("r20a", 0, 1'b0, 32'h20, 32'h0, 4'h0, 3'b000, rd, er, cyc);
`ifdef APB_SLAVE_PROT_CHECK_EN
    chk("prot0_data", rd, 32'h0);
`else
    chk("prot0_data", rd, 32'h13579BDF);
`endif
    chk("prot_rd_err", 32'(er), 32'd0);
    bus_idle();
    xfer("w20p1", 0, 1'b1, 32'h20, 32'h2468ACE0, 4'hF, 3'b001, rd, er, cyc);
    chk("prot1_err", 32'(er), 32'd0);
    bus_idle();
    xfer("r20b", 0, 1'b0, 32'h20, 32'h0, 4'h0, 3'b001, rd, er, cyc);
    chk("prot1_data", rd, 32'h2468ACE0);
    bus_idle();

    // reset asserted mid-wait
    @(posedge pclk); #1;
    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h20; pwdata = 32'h5A5A5A5A;
    pstrb = 4'hF; pprot = 3'b001;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    preset_n = 1'b0;
    #1;
    chk("rstw_rdy", 32'(pready3), 32'd0);
    chk("rstw_rd", prdata3, 32'd0);
    chk("rstw_err", 32'(pslverr3), 32'd0);
    psel3 = 1'b0; penable = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    preset_n = 1'b1;
    xfer("r20c", 3, 1'b0, 32'h20, 32'h0, 4'h0, 3'b001, rd, er, cyc);
    chk("rstw_nowrite", rd, 32'h0);
    bus_idle();
    xfer("r04d", 0, 1'b0, 32'h04, 32'h0, 4'h0, 3'b001, rd, er, cyc);
    chk("rst_clears", rd, 32'h0);
    bus_idle();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
